perf_phase_ctrl: RTL and testbench

PERF_PHASE_CTRL -- requirements
Module: perf_phase_ctrl

---
 rtl/perf_phase_ctrl.sv | 155 +++++++++++++++
 tb/tb_perf_phase_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_phase_ctrl.sv
// rtl/perf_phase_ctrl.sv - transaction sequencer with per-phase cycle counters
//
// Purpose: runs one read/compute/write transaction per software request,
// emits a one-cycle launch pulse, tracks the three engine phases
// concurrently and records saturating cycle counts for each phase and for
// the whole transaction. Completion uses a four-phase req/done handshake.
//
// Ports:
//   ACLK, ARESET            clock, asynchronous active-high reset
//   tx_req / tx_done        level request in / level completion out
//   start                   one-cycle launch pulse to the engines
//   rd_last/pr_last/wr_last one-cycle phase-finished pulses from the engines
//   rd_done/processing_done/wr_done  sticky phase-complete flags
//   total_cycles/rd_cycles/pr_cycles/wr_cycles  saturating counters
module perf_phase_ctrl #(
  parameter int PERF_CNTR_WIDTH = 32
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       tx_req,
  output logic                       tx_done,
  output logic                       start,
  input  logic                       rd_last,
  input  logic                       pr_last,
  input  logic                       wr_last,
  output logic                       rd_done,
  output logic                       processing_done,
  output logic                       wr_done,
  output logic [PERF_CNTR_WIDTH-1:0] total_cycles,
  output logic [PERF_CNTR_WIDTH-1:0] rd_cycles,
  output logic [PERF_CNTR_WIDTH-1:0] pr_cycles,
  output logic [PERF_CNTR_WIDTH-1:0] wr_cycles
);

  localparam int W = PERF_CNTR_WIDTH;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e         state_q, state_d;
  logic           start_q, start_d;
  logic           tx_done_q, tx_done_d;
  logic           rd_done_q, rd_done_d;
  logic           pr_done_q, pr_done_d;
  logic           wr_done_q, wr_done_d;
  logic [W-1:0]   total_q, total_d;
  logic [W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [W-1:0]   pr_cnt_q, pr_cnt_d;
  logic [W-1:0]   wr_cnt_q, wr_cnt_d;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    tx_done_d = tx_done_q;
    rd_done_d = rd_done_q;
    pr_done_d = pr_done_q;
    wr_done_d = wr_done_q;
    total_d   = total_q;
    rd_cnt_d  = rd_cnt_q;
    pr_cnt_d  = pr_cnt_q;
    wr_cnt_d  = wr_cnt_q;

    case (state_q)
      IDLE: begin
        // Results stay readable in IDLE; they are wiped only on a new start.
        if (tx_req) begin
          state_d   = BUSY;
          start_d   = 1'b1;
          tx_done_d = 1'b0;
          rd_done_d = 1'b0;
          pr_done_d = 1'b0;
          wr_done_d = 1'b0;
          total_d   = '0;
          rd_cnt_d  = '0;
          pr_cnt_d  = '0;
          wr_cnt_d  = '0;
        end
      end
      BUSY: begin
        total_d = sat_inc(total_q);
        // A phase counts the edge carrying its last pulse, then freezes;
        // repeated pulses after the flag is set fall through unused.
        if (!rd_done_q) begin
          rd_cnt_d = sat_inc(rd_cnt_q);
          if (rd_last) rd_done_d = 1'b1;
        end
        if (!pr_done_q) begin
          pr_cnt_d = sat_inc(pr_cnt_q);
          if (pr_last) pr_done_d = 1'b1;
        end
        if (!wr_done_q) begin
          wr_cnt_d = sat_inc(wr_cnt_q);
          if (wr_last) wr_done_d = 1'b1;
        end
        if (rd_done_d && pr_done_d && wr_done_d) begin
          state_d   = DONE;
          tx_done_d = 1'b1;
        end
      end
      DONE: begin
        // Wait for software to drop the request before re-arming.
        if (!tx_req) begin
          state_d   = IDLE;
          tx_done_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        tx_done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      tx_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      pr_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      total_q   <= '0;
      rd_cnt_q  <= '0;
      pr_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      tx_done_q <= tx_done_d;
      rd_done_q <= rd_done_d;
      pr_done_q <= pr_done_d;
      wr_done_q <= wr_done_d;
      total_q   <= total_d;
      rd_cnt_q  <= rd_cnt_d;
      pr_cnt_q  <= pr_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  assign start           = start_q;
  assign tx_done         = tx_done_q;
  assign rd_done         = rd_done_q;
  assign processing_done = pr_done_q;
  assign wr_done         = wr_done_q;
  assign total_cycles    = total_q;
  assign rd_cycles       = rd_cnt_q;
  assign pr_cycles       = pr_cnt_q;
  assign wr_cycles       = wr_cnt_q;

endmodule

// File: tb/tb_perf_phase_ctrl.sv
// tb/tb_perf_phase_ctrl.sv - self-checking bench for perf_phase_ctrl
module tb_perf_phase_ctrl;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic tx_req = 1'b0;
  logic rd_last = 1'b0;
  logic pr_last = 1'b0;
  logic wr_last = 1'b0;

  logic        w_tx_done, w_start, w_rd_done, w_pr_done, w_wr_done;
  logic [31:0] w_total, w_rd, w_pr, w_wr;
  logic        n_tx_done, n_start, n_rd_done, n_pr_done, n_wr_done;
  logic [3:0]  n_total, n_rd, n_pr, n_wr;

  int checks = 0;
  int errors = 0;

  typedef longint snap_t [18];
  string nm [9] = '{"tx_done", "start", "rd_done", "processing_done", "wr_done",
                    "total_cycles", "rd_cycles", "pr_cycles", "wr_cycles"};

  always #5 ACLK = ~ACLK;

  perf_phase_ctrl #(.PERF_CNTR_WIDTH(32)) u_wide (
    .ACLK(ACLK), .ARESET(ARESET), .tx_req(tx_req), .tx_done(w_tx_done),
    .start(w_start), .rd_last(rd_last), .pr_last(pr_last), .wr_last(wr_last),
    .rd_done(w_rd_done), .processing_done(w_pr_done), .wr_done(w_wr_done),
    .total_cycles(w_total), .rd_cycles(w_rd), .pr_cycles(w_pr), .wr_cycles(w_wr)
  );

  perf_phase_ctrl #(.PERF_CNTR_WIDTH(4)) u_narrow (
    .ACLK(ACLK), .ARESET(ARESET), .tx_req(tx_req), .tx_done(n_tx_done),
    .start(n_start), .rd_last(rd_last), .pr_last(pr_last), .wr_last(wr_last),
    .rd_done(n_rd_done), .processing_done(n_pr_done), .wr_done(n_wr_done),
    .total_cycles(n_total), .rd_cycles(n_rd), .pr_cycles(n_pr), .wr_cycles(n_wr)
  );

  task automatic step();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  function automatic longint lmin(longint a, longint b);
    return (a < b) ? a : b;
  endfunction

  function automatic snap_t observe();
    snap_t o;
    o[0] = w_tx_done; o[1] = w_start; o[2] = w_rd_done; o[3] = w_pr_done; o[4] = w_wr_done;
    o[5] = w_total;   o[6] = w_rd;    o[7] = w_pr;      o[8] = w_wr;
    o[9] = n_tx_done; o[10] = n_start; o[11] = n_rd_done; o[12] = n_pr_done; o[13] = n_wr_done;
    o[14] = n_total;  o[15] = n_rd;    o[16] = n_pr;      o[17] = n_wr;
    return o;
  endfunction

  // Reference: after k BUSY edges, a phase whose first last pulse came at
  // edge e has counted min(k,e) cycles; everything clipped at 2^W-1.
  function automatic snap_t model(int k, int er, int ep, int ew, bit st, bit td);
    snap_t x;
    for (int j = 0; j < 2; j++) begin
      int     w  = (j == 0) ? 32 : 4;
      longint mx = (longint'(1) << w) - 1;
      int     b  = j * 9;
      x[b+0] = td;
      x[b+1] = st;
      x[b+2] = (k >= er);
      x[b+3] = (k >= ep);
      x[b+4] = (k >= ew);
      x[b+5] = lmin(k, mx);
      x[b+6] = lmin(lmin(k, er), mx);
      x[b+7] = lmin(lmin(k, ep), mx);
      x[b+8] = lmin(lmin(k, ew), mx);
    end
    return x;
  endfunction

  // mode 0: clean pulses; 1: duplicate last pulses on every later edge and
  // pulses on the IDLE-exit edge and in DONE; 2: random duplicates and
  // random tx_req drops while BUSY.
  task automatic do_transaction(input string tag, input int er, input int ep,
                                input int ew, input int hold, input int mode);
    snap_t o, x;
    int emax;
    emax = er;
    if (ep > emax) emax = ep;
    if (ew > emax) emax = ew;

    tx_req  = 1'b1;
    rd_last = (mode != 0);
    pr_last = (mode != 0);
    wr_last = (mode != 0);
    step();
    o = observe();
    x = model(0, er, ep, ew, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) begin
      checks++;
      if (o[i] !== x[i]) begin
        errors++;
        $display("FAIL %s launch %s%s: got %0d expected %0d", tag, (i < 9) ? "w_" : "n_", nm[i % 9], o[i], x[i]);
      end
    end

    for (int k = 1; k <= emax; k++) begin
      rd_last = (k == er) || (k > er && (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)));
      pr_last = (k == ep) || (k > ep && (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)));
      wr_last = (k == ew) || (k > ew && (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)));
      if (mode == 2) tx_req = 1'($urandom_range(0, 1));
      step();
      o = observe();
      x = model(k, er, ep, ew, 1'b0, k == emax);
      for (int i = 0; i < 18; i++) begin
        checks++;
        if (o[i] !== x[i]) begin
          errors++;
          $display("FAIL %s busy edge %0d %s%s: got %0d expected %0d", tag, k, (i < 9) ? "w_" : "n_", nm[i % 9], o[i], x[i]);
        end
      end
    end

    tx_req = 1'b1;
    for (int h = 0; h < hold; h++) begin
      rd_last = (mode != 0);
      pr_last = (mode != 0);
      wr_last = (mode != 0);
      step();
      o = observe();
      x = model(emax, er, ep, ew, 1'b0, 1'b1);
      for (int i = 0; i < 18; i++) begin
        checks++;
        if (o[i] !== x[i]) begin
          errors++;
          $display("FAIL %s done hold %0d %s%s: got %0d expected %0d", tag, h, (i < 9) ? "w_" : "n_", nm[i % 9], o[i], x[i]);
        end
      end
    end

    // Drop the request, then idle one more edge: results must persist.
    tx_req = 1'b0;
    for (int h = 0; h < 2; h++) begin
      rd_last = (mode != 0);
      pr_last = (mode != 0);
      wr_last = (mode != 0);
      step();
      o = observe();
      x = model(emax, er, ep, ew, 1'b0, 1'b0);
      for (int i = 0; i < 18; i++) begin
        checks++;
        if (o[i] !== x[i]) begin
          errors++;
          $display("FAIL %s idle %0d %s%s: got %0d expected %0d", tag, h, (i < 9) ? "w_" : "n_", nm[i % 9], o[i], x[i]);
        end
      end
    end
    rd_last = 1'b0;
    pr_last = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic test_reset();
    snap_t o, x;
    step();
    step();
    o = observe();
    x = model(0, 1, 1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      checks++;
      if (o[i] !== x[i]) begin
        errors++;
        $display("FAIL reset_hold %s%s: got %0d expected %0d", (i < 9) ? "w_" : "n_", nm[i % 9], o[i], x[i]);
      end
    end
    ARESET = 1'b0;
    tx_req = 1'b1;
    step();
    step();
    step();
    step();
    checks++;
    if (w_total !== 32'd3) begin
      errors++;
      $display("FAIL reset_pre_total: got %0d expected 3", w_total);
    end
    // Assert reset between edges; outputs must clear without a clock.
    #1 ARESET = 1'b1;
    #1;
    o = observe();
    for (int i = 0; i < 18; i++) begin
      checks++;
      if (o[i] !== x[i]) begin
        errors++;
        $display("FAIL reset_async %s%s: got %0d expected %0d", (i < 9) ? "w_" : "n_", nm[i % 9], o[i], x[i]);
      end
    end
    @(negedge ACLK);
    ARESET = 1'b0;
    step();
    checks++;
    if (w_start !== 1'b1 || n_start !== 1'b1 || w_total !== 32'd0) begin
      errors++;
      $display("FAIL reset_restart: start got %0d/%0d expected 1, total got %0d expected 0", w_start, n_start, w_total);
    end
    rd_last = 1'b1;
    pr_last = 1'b1;
    wr_last = 1'b1;
    step();
    rd_last = 1'b0;
    pr_last = 1'b0;
    wr_last = 1'b0;
    checks++;
    if (w_tx_done !== 1'b1 || w_total !== 32'd1) begin
      errors++;
      $display("FAIL reset_finish: tx_done got %0d expected 1, total got %0d expected 1", w_tx_done, w_total);
    end
    tx_req = 1'b0;
    step();
    checks++;
    if (w_tx_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: tx_done got %0d expected 0", w_tx_done);
    end
  endtask

  task automatic test_staggered();
    do_transaction("staggered", 3, 5, 7, 2, 0);
  endtask

  task automatic test_simultaneous();
    do_transaction("simultaneous", 1, 1, 1, 1, 0);
  endtask

  task automatic test_saturation();
    do_transaction("saturation", 2, 2, 20, 1, 0);
  endtask

  task automatic test_handshake();
    do_transaction("handshake", 4, 2, 3, 10, 0);
  endtask

  task automatic test_spurious();
    rd_last = 1'b1;
    step();
    rd_last = 1'b0;
    checks++;
    if (w_rd !== 32'd4 || w_tx_done !== 1'b0 || w_start !== 1'b0) begin
      errors++;
      $display("FAIL spurious_idle: rd_cycles got %0d expected 4, tx_done %0d, start %0d", w_rd, w_tx_done, w_start);
    end
    do_transaction("spurious", 2, 4, 6, 3, 1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 15; t++) begin
      do_transaction($sformatf("random%0d", t), $urandom_range(1, 24), $urandom_range(1, 24),
                     $urandom_range(1, 24), $urandom_range(0, 3), 2);
    end
  endtask

  initial begin
    test_reset();
    test_staggered();
    test_simultaneous();
    test_saturation();
    test_handshake();
    test_spurious();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
